// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the ID-side redirect controller and its IF/ID register:
//   - control-flow opcodes (instr[15:12])
//   - fetch PC select encodings driven on PCSrc
//   - redirect controller state enum
//   - wait-cycle limit used when REDIRECT_TIMEOUT_EN is defined
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] PCSRC_INC  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_CALL = 2'b10;
  localparam logic [1:0] PCSRC_RET  = 2'b11;

  localparam int TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_BR  = 2'd1,
    WAIT_RET = 2'd2,
    HALT     = 2'd3
  } ctrl_state_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] ins);
    return ins[15:12];
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// -----------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register with hold and squash, plus a saturating bubble counter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   hold            keep current contents (no load this cycle)
//   squash          load this cycle as a bubble (valid cleared)
//   instr, pc_inc   fetch-side instruction and PC+1
//   ifid_instr      registered instruction
//   ifid_pc_inc     registered PC+1
//   ifid_valid      register holds a real instruction
//   bubble_cnt      number of cycles a bubble was loaded, saturating at all-ones
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module ifid_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              squash,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc_inc,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_pc_inc,
  output logic              ifid_valid,
  output logic [15:0]       bubble_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // IF -> ID stage boundary; the payload is loaded even on a squash so that
  // call_imm downstream always reflects the register contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr  <= '0;
      ifid_pc_inc <= '0;
      ifid_valid  <= 1'b0;
      bubble_cnt  <= 16'd0;
    end else if (!hold) begin
      ifid_instr  <= instr;
      ifid_pc_inc <= pc_inc;
      ifid_valid  <= !squash;
      if (squash) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

endmodule

// File: rtl/id_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// id_redirect_ctrl
// ID-side consumer/controller of the fetch interface. Captures fetch output into
// IF/ID, pre-decodes control-flow opcodes and steers fetch (PCSrc, pc_ld,
// call_imm). Branches and returns park the controller in a wait state that
// loads bubbles until EX (branch) or MEM (return) resolves; HALT parks until rst.
//
// Optional build macro REDIRECT_TIMEOUT_EN: a wait counter forces a return to
// RUN after TIMEOUT_CYC unresolved wait cycles and sets sticky timeout_err.
// Without the macro the wait states wait indefinitely and timeout_err is 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   instr, PC_inc       instruction and PC+1 from fetch
//   stall               hazard-unit hold of IF/ID (honoured in RUN only)
//   br_resolved/br_taken  EX branch outcome
//   ret_valid           MEM return address valid on fetch's ret input
//   PCSrc, pc_ld        fetch PC select and load enable (combinational)
//   call_imm            low 12 bits of call target, always ifid_instr[11:0]
//   ifid_instr, ifid_pc_inc, ifid_valid   IF/ID register
//   bubble_cnt          saturating bubble cycle count
//   timeout_err         sticky wait timeout flag
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module id_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic [15:0] PC_inc,
  input  logic        stall,
  input  logic        br_resolved,
  input  logic        br_taken,
  input  logic        ret_valid,
  output logic [1:0]  PCSrc,
  output logic        pc_ld,
  output logic [11:0] call_imm,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_inc,
  output logic        ifid_valid,
  output logic [15:0] bubble_cnt,
  output logic        timeout_err
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  logic        hold;
  logic        squash;
  logic [3:0]  op;

`ifdef REDIRECT_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_hit;
  logic        timeout_err_q;
`endif

  assign op       = opcode_of(ifid_instr);
  assign call_imm = ifid_instr[11:0];

  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    squash  = 1'b0;
    PCSrc   = PCSRC_INC;
    pc_ld   = 1'b1;
`ifdef REDIRECT_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      RUN: begin
        if (stall) begin
          hold  = 1'b1;
          pc_ld = 1'b0;
        end else if (ifid_valid) begin
          // Decode acts exactly once: the instruction leaves IF/ID this cycle.
          case (op)
            OP_CALL: begin
              PCSrc  = PCSRC_CALL;
              squash = 1'b1;
            end
            OP_B: begin
              pc_ld   = 1'b0;
              squash  = 1'b1;
              state_d = WAIT_BR;
            end
            OP_RET: begin
              pc_ld   = 1'b0;
              squash  = 1'b1;
              state_d = WAIT_RET;
            end
            OP_HLT: begin
              pc_ld   = 1'b0;
              squash  = 1'b1;
              state_d = HALT;
            end
            default: ;
          endcase
        end
      end
      WAIT_BR: begin
        if (br_resolved) begin
          // Not-taken: fetch already holds the fall-through, capture it valid.
          state_d = RUN;
          if (br_taken) begin
            PCSrc  = PCSRC_BR;
            squash = 1'b1;
          end
        end else begin
          pc_ld  = 1'b0;
          squash = 1'b1;
`ifdef REDIRECT_TIMEOUT_EN
          if (wait_cnt == 16'(TIMEOUT_CYC)) begin
            timeout_hit = 1'b1;
            pc_ld       = 1'b1;
            state_d     = RUN;
          end
`endif
        end
      end
      WAIT_RET: begin
        if (ret_valid) begin
          PCSrc   = PCSRC_RET;
          squash  = 1'b1;
          state_d = RUN;
        end else begin
          pc_ld  = 1'b0;
          squash = 1'b1;
`ifdef REDIRECT_TIMEOUT_EN
          if (wait_cnt == 16'(TIMEOUT_CYC)) begin
            timeout_hit = 1'b1;
            pc_ld       = 1'b1;
            state_d     = RUN;
          end
`endif
        end
      end
      HALT: begin
        pc_ld  = 1'b0;
        squash = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

`ifdef REDIRECT_TIMEOUT_EN
  // Counter sits at zero outside the wait states, so it is clear on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt      <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == WAIT_BR || state_q == WAIT_RET) wait_cnt <= wait_cnt + 16'd1;
      else                                           wait_cnt <= 16'd0;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  ifid_reg #(.DATA_W(16)) u_ifid (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .squash      (squash),
    .instr       (instr),
    .pc_inc      (PC_inc),
    .ifid_instr  (ifid_instr),
    .ifid_pc_inc (ifid_pc_inc),
    .ifid_valid  (ifid_valid),
    .bubble_cnt  (bubble_cnt)
  );

endmodule

// File: tb/tb_id_redirect_ctrl.sv
module tb_id_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr, PC_inc;
  logic        stall, br_resolved, br_taken, ret_valid;
  logic [1:0]  PCSrc;
  logic        pc_ld;
  logic [11:0] call_imm;
  logic [15:0] ifid_instr, ifid_pc_inc;
  logic        ifid_valid;
  logic [15:0] bubble_cnt;
  logic        timeout_err;

  id_redirect_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .PC_inc(PC_inc), .stall(stall),
    .br_resolved(br_resolved), .br_taken(br_taken), .ret_valid(ret_valid),
    .PCSrc(PCSrc), .pc_ld(pc_ld), .call_imm(call_imm),
    .ifid_instr(ifid_instr), .ifid_pc_inc(ifid_pc_inc), .ifid_valid(ifid_valid),
    .bubble_cnt(bubble_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

`ifdef REDIRECT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_LIMIT = 16;

  typedef struct packed { logic [1:0] pcsrc; logic ld; logic [11:0] imm; } comb_t;
  typedef struct packed {
    logic [15:0] ins; logic [15:0] pc; logic v; logic [15:0] bc; logic te;
  } reg_t;

  comb_t cq[$];
  reg_t  rq[$];
  int total = 0;
  int bad   = 0;

  // Reference model: what the IF/ID register should hold and how the
  // controller is parked, in terms of the behavioural rules.
  typedef enum { M_RUN, M_WAIT_BR, M_WAIT_RET, M_HALT } mode_e;
  mode_e       m_mode;
  logic [15:0] m_ins, m_pc;
  bit          m_v, m_te;
  int          m_bc, m_waited;

  task automatic m_reset();
    m_mode = M_RUN; m_ins = 16'h0; m_pc = 16'h0; m_v = 0; m_te = 0;
    m_bc = 0; m_waited = 0;
  endtask

  task automatic model(input bit r, input logic [15:0] i, input logic [15:0] p,
                       input bit s, input bit brr, input bit brt, input bit rv);
    comb_t c;
    reg_t  q;
    bit keep, take_valid;
    if (r) m_reset();
    c.pcsrc = 2'd0; c.ld = 1'b1; c.imm = m_ins[11:0];
    keep = 0; take_valid = 1;
    case (m_mode)
      M_RUN: begin
        if (s) begin keep = 1; c.ld = 0; end
        else if (m_v) begin
          if (m_ins[15:12] == 4'hD) begin c.pcsrc = 2'd2; take_valid = 0; end
          else if (m_ins[15:12] == 4'hC) begin
            c.ld = 0; take_valid = 0; m_mode = M_WAIT_BR; m_waited = 0;
          end else if (m_ins[15:12] == 4'hE) begin
            c.ld = 0; take_valid = 0; m_mode = M_WAIT_RET; m_waited = 0;
          end else if (m_ins[15:12] == 4'hF) begin
            c.ld = 0; take_valid = 0; m_mode = M_HALT;
          end
        end
      end
      M_WAIT_BR, M_WAIT_RET: begin
        if (m_mode == M_WAIT_BR && brr) begin
          m_mode = M_RUN;
          if (brt) begin c.pcsrc = 2'd1; take_valid = 0; end
        end else if (m_mode == M_WAIT_RET && rv) begin
          m_mode = M_RUN; c.pcsrc = 2'd3; take_valid = 0;
        end else if (TO_EN && m_waited == TO_LIMIT) begin
          m_mode = M_RUN; m_te = 1; take_valid = 0;
        end else begin
          c.ld = 0; take_valid = 0; m_waited++;
        end
      end
      default: begin c.ld = 0; take_valid = 0; end
    endcase
    if (!r && !keep) begin
      m_ins = i; m_pc = p; m_v = take_valid;
      if (!take_valid && m_bc < 65535) m_bc++;
    end
    q.ins = m_ins; q.pc = m_pc; q.v = m_v; q.bc = 16'(m_bc); q.te = m_te;
    cq.push_back(c);
    rq.push_back(q);
  endtask

  task automatic cyc(input bit r, input logic [15:0] i, input logic [15:0] p,
                     input bit s, input bit brr, input bit brt, input bit rv);
    @(negedge clk);
    rst = r; instr = i; PC_inc = p; stall = s;
    br_resolved = brr; br_taken = brt; ret_valid = rv;
    model(r, i, p, s, brr, brt, rv);
  endtask

  task automatic idle(input int n, input logic [15:0] i, input logic [15:0] p);
    for (int k = 0; k < n; k++) cyc(0, i, p + 16'(k), 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: comb outputs sampled 2 time units after inputs change at the
  // falling edge; registered outputs sampled 1 unit after the rising edge.
  initial begin
    comb_t c;
    reg_t  q;
    forever begin
      @(negedge clk); #2;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("PCSrc", 32'(PCSrc), 32'(c.pcsrc));
        chk("pc_ld", 32'(pc_ld), 32'(c.ld));
        chk("call_imm", 32'(call_imm), 32'(c.imm));
      end
      @(posedge clk); #1;
      if (rq.size() > 0) begin
        q = rq.pop_front();
        chk("ifid_instr", 32'(ifid_instr), 32'(q.ins));
        chk("ifid_pc_inc", 32'(ifid_pc_inc), 32'(q.pc));
        chk("ifid_valid", 32'(ifid_valid), 32'(q.v));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(q.bc));
        chk("timeout_err", 32'(timeout_err), 32'(q.te));
      end
    end
  end

  initial begin
    logic [15:0] ri;
    int pick;
    rst = 1; instr = 0; PC_inc = 0; stall = 0;
    br_resolved = 0; br_taken = 0; ret_valid = 0;
    m_reset();

    cyc(1, 16'h0, 16'h0, 0, 0, 0, 0);
    cyc(1, 16'h0, 16'h0, 0, 0, 0, 0);
    // straight-line
    cyc(0, 16'h1234, 16'd1, 0, 0, 0, 0);
    cyc(0, 16'h2345, 16'd2, 0, 0, 0, 0);
    cyc(0, 16'h3456, 16'd3, 0, 0, 0, 0);
    // call
    cyc(0, 16'hD0A5, 16'd4, 0, 0, 0, 0);
    idle(3, 16'h1111, 16'd5);
    // branch taken after 3 bubbles
    cyc(0, 16'hC003, 16'd8, 0, 0, 0, 0);
    idle(3, 16'h4444, 16'd9);
    cyc(0, 16'h4444, 16'd12, 0, 1, 1, 0);
    idle(2, 16'h5555, 16'd13);
    // branch not taken
    cyc(0, 16'hC003, 16'd20, 0, 0, 0, 0);
    idle(3, 16'h6666, 16'd21);
    cyc(0, 16'h7777, 16'd24, 0, 0, 1, 0);
    cyc(0, 16'h7777, 16'd24, 0, 1, 0, 0);
    idle(2, 16'h0101, 16'd25);
    // return with ignored branch pulse
    cyc(0, 16'hE000, 16'd30, 0, 0, 0, 0);
    cyc(0, 16'h0202, 16'd31, 0, 0, 0, 0);
    cyc(0, 16'h0202, 16'd31, 0, 1, 1, 0);
    idle(2, 16'h0202, 16'd31);
    cyc(0, 16'h0303, 16'd32, 0, 0, 0, 1);
    idle(2, 16'h0404, 16'd33);
    // stall with a call sitting in IF/ID
    cyc(0, 16'hD123, 16'd40, 0, 0, 0, 0);
    cyc(0, 16'h0505, 16'd41, 1, 0, 0, 0);
    cyc(0, 16'h0505, 16'd41, 1, 0, 0, 0);
    idle(2, 16'h0505, 16'd41);
    // reset in the middle of a branch wait
    cyc(0, 16'hC010, 16'd50, 0, 0, 0, 0);
    idle(2, 16'h0606, 16'd51);
    cyc(1, 16'h0606, 16'd53, 0, 1, 1, 0);
    idle(2, 16'h0707, 16'd54);
    // unresolved wait: timeout when enabled, indefinite wait otherwise
    cyc(0, 16'hC020, 16'd60, 0, 0, 0, 0);
    idle(22, 16'h0808, 16'd61);
    cyc(0, 16'hE000, 16'd90, 0, 0, 0, 0);
    idle(20, 16'h0909, 16'd91);
    cyc(1, 16'h0, 16'h0, 0, 0, 0, 0);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      pick = $urandom_range(0, 39);
      ri = 16'($urandom);
      if (pick < 4)       ri[15:12] = 4'hC;
      else if (pick < 7)  ri[15:12] = 4'hD;
      else if (pick < 9)  ri[15:12] = 4'hE;
      else if (pick == 9) ri[15:12] = 4'hF;
      else                ri[15:12] = 4'($urandom_range(0, 11));
      cyc(($urandom_range(0, 49) == 0), ri, 16'($urandom),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
          1'($urandom), ($urandom_range(0, 5) == 0));
    end
    // halt long enough to saturate the bubble counter
    cyc(1, 16'h0, 16'h0, 0, 0, 0, 0);
    cyc(0, 16'hF000, 16'd1, 0, 0, 0, 0);
    for (int n = 0; n < 65540; n++) cyc(0, 16'h1000, 16'(n), 0, 1, 1, 1);
    cyc(1, 16'h0, 16'h0, 0, 0, 0, 0);
    idle(2, 16'h1234, 16'd1);

    repeat (3) @(negedge clk);
    chk("queue_drain", 32'(cq.size() + rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_redirect_ctrl.md
Name: id_redirect_ctrl

Overview:
- Consumer and controller side of the fetch interface. Captures the fetched instruction and its PC_inc into the IF/ID pipeline register.
- Pre-decodes control-flow opcodes and drives the fetch stage's PCSrc select, PC load enable and 12-bit call immediate.
- Holds fetch and inserts bubbles while a branch resolves in EX or a return address comes back from MEM.
- Sits between the fetch slice and the ID stage.

Parameters:
- OP_B, 4'hC: opcode [15:12] of conditional branch.
- OP_CALL, 4'hD: opcode of call. Target is {PC_inc[15:12], instr[11:0]}.
- OP_RET, 4'hE: opcode of return.
- OP_HLT, 4'hF: opcode of halt.
- TIMEOUT_CYC, 16: wait-cycle limit. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  16  instruction from fetch.
- PC_inc  in  16  PC+1 from fetch.
- stall  in  1  hazard-unit stall of the IF/ID register.
- br_resolved  in  1  EX: branch outcome valid this cycle.
- br_taken  in  1  EX: branch taken; qualified by br_resolved.
- ret_valid  in  1  MEM: return address valid on fetch's ret input this cycle.
- PCSrc  out  2  fetch select: 00 inc, 01 branch, 10 call, 11 ret.
- pc_ld  out  1  fetch PC load enable.
- call_imm  out  12  call target low bits.
- ifid_instr  out  16  IF/ID instruction.
- ifid_pc_inc  out  16  IF/ID PC+1.
- ifid_valid  out  1  IF/ID holds a real instruction.
- bubble_cnt  out  16  saturating count of bubble cycles.
- timeout_err  out  1  sticky timeout flag. Tied 0 without the macro.

Behaviour:
- Reset (async): state RUN; ifid_instr=0, ifid_pc_inc=0, ifid_valid=0, bubble_cnt=0, timeout_err=0.
- PCSrc, pc_ld and call_imm are combinational from state and IF/ID. Their reset values are 00, 1 and 0.
- call_imm = ifid_instr[11:0] always. Fetch samples it only when PCSrc=10.
- "act" = ifid_valid & !stall & state==RUN. The IF/ID instruction takes effect only when act is true, and exactly once per captured instruction.
- RUN with stall=1: IF/ID holds, pc_ld=0, PCSrc=00, no decode action. br_resolved and ret_valid are ignored in RUN.
- RUN, act, opcode OP_CALL: PCSrc=10, pc_ld=1. The next capture is squashed (ifid_valid<=0) because it is wrong-path.
- RUN, act, opcode OP_B: pc_ld=0, PCSrc=00. Next state WAIT_BR. The next capture is a bubble.
- RUN, act, opcode OP_RET: same as OP_B, but next state WAIT_RET.
- RUN, act, opcode OP_HLT: pc_ld=0. Next state HALT.
- RUN, act, any other opcode: PCSrc=00, pc_ld=1, capture instr/PC_inc with ifid_valid<=1.
- WAIT_BR:
  - pc_ld=0 and bubbles captured, until br_resolved=1.
  - br_taken=1: PCSrc=01, pc_ld=1, the capture this cycle is squashed, then RUN.
  - br_taken=0: PCSrc=00, pc_ld=1, the current instr is captured valid (it is the fall-through), then RUN.
  - ret_valid is ignored in WAIT_BR. stall is ignored in WAIT states.
- WAIT_RET:
  - pc_ld=0 and bubbles until ret_valid=1.
  - On ret_valid: PCSrc=11, pc_ld=1, the capture is squashed, then RUN.
  - br_resolved is ignored in WAIT_RET.
- HALT: pc_ld=0, ifid_valid<=0 every cycle. Only rst exits.
- bubble_cnt increments on every cycle where ifid_valid<=0 is loaded. It saturates at 16'hFFFF and does not wrap.
- Reset asserted mid-WAIT or mid-HALT aborts immediately. Any pending resolution is dropped.

Optional Feature:
- REDIRECT_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on WAIT_BR/WAIT_RET entry and increments each cycle in those states.
  - When it reaches TIMEOUT_CYC without a resolution: timeout_err<=1 (sticky until rst), PCSrc=00, pc_ld=1, return to RUN.
  - A resolution arriving in the same cycle takes priority over the timeout.
- REDIRECT_TIMEOUT_EN undefined: no counter; WAIT states wait indefinitely; timeout_err tied 0.

Decomposition:
- cpu_pkg holds:
  - opcode localparams (OP_B/CALL/RET/HLT);
  - PCSrc encodings PCSRC_INC/BR/CALL/RET;
  - the state enum {RUN, WAIT_BR, WAIT_RET, HALT}.
- One sub-module, ifid_reg: IF/ID register with hold (stall) and squash inputs, plus the bubble counter.
- The FSM and decode stay in the top module.

Test Plan:
- Straight-line: after rst, instr 16'h1234/PC_inc 1, then 16'h2345/2 -> ifid_instr 1234 then 2345 one cycle later, valid=1, PCSrc=00, pc_ld=1 throughout.
- Call: 16'hD0A5 captured -> act cycle PCSrc=10, call_imm=12'h0A5, pc_ld=1; next cycle ifid_valid=0, bubble_cnt=1.
- Branch: 16'hC003 captured -> pc_ld=0 and 3 bubbles.
  - br_resolved=1, br_taken=1 -> PCSrc=01, pc_ld=1, next ifid_valid=0.
  - Repeat with br_taken=0 -> PCSrc=00, fall-through instr captured valid.
- Return: 16'hE000 -> WAIT_RET; br_resolved pulse ignored; ret_valid after 4 cycles -> PCSrc=11 for exactly one cycle, then RUN.
- Stall: CALL in IF/ID with stall=1 for 2 cycles -> ifid unchanged, pc_ld=0, PCSrc=00; after release PCSrc=10 exactly once.
- Reset mid-WAIT_BR, and timeout (macro on, TIMEOUT_CYC=16, no resolution):
  - rst -> all outputs at reset values, RUN.
  - Timeout -> after 16 wait cycles timeout_err=1, pc_ld=1, PCSrc=00; timeout_err stays 1 until rst.
